// File: rtl/i2c_bus_frontend.sv
// I2C pin front end: synchronizes sda/scl and turns them into START/STOP, bit, byte and ACK pulses.
// Optional glitch filter on both lines is compiled in with `define I2C_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module i2c_bus_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       start_det,
  output logic       stop_det,
  output logic       bit_valid,
  output logic       bit_val,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ack_valid,
  output logic       ack_bit,
  output logic       bus_busy,
  output logic       frame_err
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_cfg
    $error("i2c_bus_frontend: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  typedef enum logic [1:0] {StIdle, StData, StAck} state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s;
  logic                   scl_c, sda_c;
  logic                   prev_scl, prev_sda;
  logic                   start_ev, stop_ev, rise_ev;
  logic [7:0]             shift, shift_nxt;
  logic [2:0]             bit_cnt;
  state_t                 state;

  // Lines idle high, so the chains reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CntW = $clog2(FILT_LEN + 1);

  logic [CntW-1:0] scl_cnt, sda_cnt;
  logic            scl_f, sda_f;

  // Clean level flips only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CntW'(FILT_LEN - 1)) begin
        scl_f   <= scl_s;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_s == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CntW'(FILT_LEN - 1)) begin
        sda_f   <= sda_s;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  assign scl_c = scl_f;
  assign sda_c = sda_f;
`else
  assign scl_c = scl_s;
  assign sda_c = sda_s;
`endif

  // START/STOP need scl high on both samples, so a simultaneous scl+sda change is never one.
  assign start_ev  = prev_scl & scl_c & prev_sda & ~sda_c;
  assign stop_ev   = prev_scl & scl_c & ~prev_sda & sda_c;
  assign rise_ev   = ~prev_scl & scl_c;
  assign shift_nxt = {shift[6:0], sda_c};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      bit_cnt    <= '0;
      shift      <= '0;
      prev_scl   <= 1'b1;
      prev_sda   <= 1'b1;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      bit_valid  <= 1'b0;
      bit_val    <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      ack_valid  <= 1'b0;
      ack_bit    <= 1'b0;
      bus_busy   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      prev_scl   <= scl_c;
      prev_sda   <= sda_c;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      ack_valid  <= 1'b0;
      frame_err  <= 1'b0;
      if (start_ev) begin
        start_det <= 1'b1;
        frame_err <= (state == StData) && (bit_cnt != 3'd0);
        bus_busy  <= 1'b1;
        state     <= StData;
        bit_cnt   <= '0;
        shift     <= '0;
      end else if (stop_ev) begin
        stop_det  <= 1'b1;
        frame_err <= (state == StData) && (bit_cnt != 3'd0);
        bus_busy  <= 1'b0;
        state     <= StIdle;
        bit_cnt   <= '0;
      end else if (rise_ev) begin
        case (state)
          StData: begin
            shift     <= shift_nxt;
            bit_valid <= 1'b1;
            bit_val   <= sda_c;
            if (bit_cnt == 3'd7) begin
              byte_data  <= shift_nxt;
              byte_valid <= 1'b1;
              bit_cnt    <= '0;
              state      <= StAck;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          StAck: begin
            bit_valid <= 1'b1;
            bit_val   <= sda_c;
            ack_valid <= 1'b1;
            ack_bit   <= sda_c;
            bit_cnt   <= '0;
            state     <= StData;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Scoreboard bench for i2c_bus_frontend: stimulus tasks queue expected events, a negedge monitor
// pops and compares them as the DUT pulses.
`timescale 1ns/1ps
module tb_i2c_bus_frontend;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILT_LEN    = 3;
`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned FILT_LAT = FILT_LEN;
`else
  localparam int unsigned FILT_LAT = 0;
`endif
  localparam int Q = 4;
  localparam logic [7:0] KStart = 8'd0, KErr = 8'd1, KStop = 8'd2, KBit = 8'd3, KByte = 8'd4,
                         KAck = 8'd5;

  logic       clk = 1'b0, reset = 1'b1, sda_in = 1'b1, scl_in = 1'b1;
  logic       start_det, stop_det, bit_valid, bit_val, byte_valid, ack_valid, ack_bit;
  logic       bus_busy, frame_err;
  logic [7:0] byte_data;

  i2c_bus_frontend #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .reset(reset), .sda_in(sda_in), .scl_in(scl_in),
    .start_det(start_det), .stop_det(stop_det), .bit_valid(bit_valid), .bit_val(bit_val),
    .byte_valid(byte_valid), .byte_data(byte_data), .ack_valid(ack_valid), .ack_bit(ack_bit),
    .bus_busy(bus_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] obs, expv;
  bit   mon_en = 1'b0, busy_chk = 1'b1;
  logic model_busy = 1'b0;
  int   cyc = 0, n_start = 0, n_bit = 0, n_byte = 0;
  int   last_err_cyc = -1, last_stop_cyc = -2;

  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    if (mon_en) begin
      obs_q.delete();
      if (start_det)  begin obs_q.push_back({KStart, 8'h00}); n_start = n_start + 1; end
      if (frame_err)  begin obs_q.push_back({KErr, 8'h00}); last_err_cyc = cyc; end
      if (stop_det)   begin obs_q.push_back({KStop, 8'h00}); last_stop_cyc = cyc; end
      if (bit_valid)  begin obs_q.push_back({KBit, 7'h00, bit_val}); n_bit = n_bit + 1; end
      if (byte_valid) begin obs_q.push_back({KByte, byte_data}); n_byte = n_byte + 1; end
      if (ack_valid)  obs_q.push_back({KAck, 7'h00, ack_bit});
      while (obs_q.size() > 0) begin
        obs = obs_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event at cycle %0d: got kind/val %h, expected none", cyc, obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            failures++;
            $display("FAIL event at cycle %0d: got kind/val %h, expected %h", cyc, obs, expv);
          end
          if (expv[15:8] == KStart) model_busy = 1'b1;
          if (expv[15:8] == KStop)  model_busy = 1'b0;
        end
      end
      if (busy_chk) begin
        checks++;
        if (bus_busy !== model_busy) begin
          failures++;
          $display("FAIL bus_busy at cycle %0d: got %b, expected %b", cyc, bus_busy, model_busy);
        end
      end
      checks++;
      if ((start_det & stop_det) !== 1'b0) begin
        failures++;
        $display("FAIL start_stop_exclusive at cycle %0d: got both high, expected at most one", cyc);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves scl low with sda at b, then raises scl; bit pulse is expected from here.
  task automatic drive_rise(input logic b);
    scl_in = 1'b0;
    cyc_wait(Q);
    sda_in = b;
    cyc_wait(Q);
    scl_in = 1'b1;
  endtask

  // Requires scl high and sda high; leaves sda low with scl high.
  task automatic send_start(input bit err);
    sda_in = 1'b0;
    exp_q.push_back({KStart, 8'h00});
    if (err) exp_q.push_back({KErr, 8'h00});
    cyc_wait(2 * Q);
  endtask

  // Requires scl high and sda low.
  task automatic send_stop(input bit err);
    sda_in = 1'b1;
    if (err) exp_q.push_back({KErr, 8'h00});
    exp_q.push_back({KStop, 8'h00});
    cyc_wait(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) begin
      drive_rise(d[i]);
      exp_q.push_back({KBit, 7'h00, d[i]});
      if (i == 0) exp_q.push_back({KByte, d});
      cyc_wait(2 * Q);
    end
    drive_rise(ack);
    exp_q.push_back({KBit, 7'h00, ack});
    exp_q.push_back({KAck, 7'h00, ack});
    cyc_wait(2 * Q);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    sda_in = 1'b1;
    scl_in = 1'b1;
    cyc_wait(4);
    @(negedge clk);
    checks++;
    if ({start_det, stop_det, bit_valid, bit_val, byte_valid, byte_data, ack_valid, ack_bit,
         bus_busy, frame_err} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    mon_en = 1'b1;
    cyc_wait(1);
    reset = 1'b0;
    cyc_wait(4);
  endtask

  task automatic test_basic_frame();
    int s0, b0, y0;
    s0 = n_start; b0 = n_bit; y0 = n_byte;
    send_start(1'b0);
    send_byte(8'hA6, 1'b0);
    send_stop(1'b0);
    checks++;
    if (n_bit - b0 !== 9) begin
      failures++; $display("FAIL basic_bit_count: got %0d, expected 9", n_bit - b0);
    end
    checks++;
    if (n_byte - y0 !== 1 || byte_data !== 8'hA6) begin
      failures++;
      $display("FAIL basic_byte: got count %0d data %h, expected 1 and a6", n_byte - y0, byte_data);
    end
    checks++;
    if (n_start - s0 !== 1 || ack_bit !== 1'b0 || bus_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_frame_end: got starts %0d ack %b busy %b, expected 1 0 0",
               n_start - s0, ack_bit, bus_busy);
    end
  endtask

  task automatic test_repeated_start();
    int s0, e0;
    s0 = n_start; e0 = last_err_cyc;
    send_start(1'b0);
    send_byte(8'h3C, 1'b1);
    checks++;
    if (ack_bit !== 1'b1) begin
      failures++; $display("FAIL rs_nack: got %b, expected 1", ack_bit);
    end
    send_start(1'b0);
    send_byte(8'hFF, 1'b0);
    send_stop(1'b0);
    checks++;
    if (n_start - s0 !== 2 || last_err_cyc !== e0) begin
      failures++;
      $display("FAIL rs_starts: got starts %0d err_cyc %0d, expected 2 and %0d",
               n_start - s0, last_err_cyc, e0);
    end
    checks++;
    if (byte_data !== 8'hFF || ack_bit !== 1'b0) begin
      failures++;
      $display("FAIL rs_second_byte: got %h ack %b, expected ff ack 0", byte_data, ack_bit);
    end
  endtask

  task automatic test_partial_stop();
    int y0;
    logic [2:0] bits;
    y0 = n_byte;
    bits = 3'b100;
    send_start(1'b0);
    for (int i = 2; i >= 0; i--) begin
      drive_rise(bits[i]);
      exp_q.push_back({KBit, 7'h00, bits[i]});
      cyc_wait(2 * Q);
    end
    send_stop(1'b1);
    checks++;
    if (last_err_cyc !== last_stop_cyc) begin
      failures++;
      $display("FAIL partial_err_cycle: got err at %0d, expected stop cycle %0d",
               last_err_cyc, last_stop_cyc);
    end
    checks++;
    if (n_byte !== y0 || bus_busy !== 1'b0) begin
      failures++;
      $display("FAIL partial_state: got bytes %0d busy %b, expected %0d and 0",
               n_byte - y0, bus_busy, 0);
    end
  endtask

  task automatic test_idle_clocks();
    int b0, y0;
    b0 = n_bit; y0 = n_byte;
    sda_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      scl_in = 1'b0;
      cyc_wait(Q);
      scl_in = 1'b1;
      cyc_wait(Q);
    end
    cyc_wait(2 * Q);
    checks++;
    if (n_bit !== b0 || n_byte !== y0 || bus_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_clocks: got bits %0d bytes %0d busy %b, expected 0 0 0",
               n_bit - b0, n_byte - y0, bus_busy);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [3:0] bits;
    bits = 4'b1011;
    send_start(1'b0);
    for (int i = 3; i >= 0; i--) begin
      drive_rise(bits[i]);
      exp_q.push_back({KBit, 7'h00, bits[i]});
      cyc_wait(2 * Q);
    end
    busy_chk = 1'b0;
    reset  = 1'b1;
    sda_in = 1'b1;
    scl_in = 1'b1;
    cyc_wait(6);
    @(negedge clk);
    checks++;
    if ({start_det, stop_det, bit_valid, byte_valid, ack_valid, bus_busy, frame_err} !== 7'h0)
    begin
      failures++; $display("FAIL reset_mid_byte_outputs: got nonzero, expected all 0");
    end
    model_busy = 1'b0;
    cyc_wait(1);
    reset = 1'b0;
    busy_chk = 1'b1;
    cyc_wait(4);
    send_start(1'b0);
    send_byte(8'h81, 1'b0);
    send_stop(1'b0);
    checks++;
    if (byte_data !== 8'h81) begin
      failures++; $display("FAIL reset_mid_byte_data: got %h, expected 81", byte_data);
    end
  endtask

  // 4-cycle sda low while scl high: a START, then a STOP when sda returns high.
  task automatic test_start_latency();
    int lat;
    lat = -1;
    sda_in = 1'b0;
    exp_q.push_back({KStart, 8'h00});
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 4) begin
        sda_in = 1'b1;
        exp_q.push_back({KStop, 8'h00});
      end
      @(negedge clk);
      if (start_det === 1'b1 && lat < 0) lat = n;
    end
    checks++;
    if (lat !== int'(SYNC_STAGES + 1 + FILT_LAT)) begin
      failures++;
      $display("FAIL start_latency: got %0d cycles, expected %0d", lat, SYNC_STAGES + 1 + FILT_LAT);
    end
    cyc_wait(2 * Q);
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch();
    int s0;
    s0 = n_start;
    sda_in = 1'b0;
    cyc_wait(2);
    sda_in = 1'b1;
    cyc_wait(12);
    checks++;
    if (n_start !== s0) begin
      failures++; $display("FAIL glitch_reject: got %0d starts, expected 0", n_start - s0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_repeated_start();
    test_partial_stop();
    test_idle_clocks();
    test_reset_mid_byte();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_start_latency();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cyc_wait(1);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++; $display("FAIL drain: got %0d events still pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_bus_frontend.md
Name: i2c_bus_frontend

Overview:
Upstream stage of the I2C sequence-matching FSM. Samples raw asynchronous sda/scl pins on the system clock and synchronizes them. Detects START and STOP conditions and recovers data bits on scl rising edges. Assembles MSB-first bytes and ACK bits, emitting single-cycle event pulses so the downstream matcher consumes clean protocol events instead of raw pin levels.

Parameters:
SYNC_STAGES, 2, flops in each pin synchronizer chain (minimum 2)
FILT_LEN, 3, consecutive identical samples required by the glitch filter (used only when the filter is compiled in)

Ports:
clk  input  1  system clock; must be at least 8x the scl rate
reset  input  1  synchronous, active-high
sda_in  input  1  raw asynchronous SDA pin level
scl_in  input  1  raw asynchronous SCL pin level
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP
bit_valid  output  1  one-cycle pulse per data or ACK bit sampled while a frame is active
bit_val  output  1  sampled sda value; qualified by bit_valid
byte_valid  output  1  one-cycle pulse when the 8th data bit of a byte is sampled
byte_data  output  8  assembled byte, MSB first; holds its value until the next byte_valid
ack_valid  output  1  one-cycle pulse when the 9th bit is sampled
ack_bit  output  1  9th-bit sda value (0 = ACK, 1 = NACK); holds its value until the next ack_valid
bus_busy  output  1  high from START until STOP
frame_err  output  1  one-cycle pulse when START or STOP arrives with a partial byte pending

Behaviour:
- Reset: all outputs 0. State IDLE, bit_cnt 0, shift register 0, prev_scl = prev_sda = 1, synchronizer and filter flops = 1. Reset mid-byte discards the partial byte; no pulses are emitted while reset is asserted or on the cycle it deasserts.
- Clean lines: scl_c and sda_c are the synchronizer outputs (filtered when the filter is compiled in). prev_scl and prev_sda register scl_c and sda_c every cycle.
- Events, evaluated each cycle:
  - START: prev_scl = 1, scl_c = 1, prev_sda = 1, sda_c = 0.
  - STOP: prev_scl = 1, scl_c = 1, prev_sda = 0, sda_c = 1.
  - RISE: prev_scl = 0, scl_c = 1. The bit value is sda_c from the same cycle.
  - If scl and sda change in the same cycle, it is a RISE or FALL, never START or STOP.
- FSM states: IDLE, DATA, ACK.
  - IDLE: RISE is ignored. START -> DATA, bit_cnt = 0, bus_busy = 1. STOP -> stop_det only.
  - DATA: each RISE shifts sda_c into the LSB and pulses bit_valid. When bit_cnt = 7, byte_data takes the full shifted value, byte_valid pulses, state -> ACK. Otherwise bit_cnt increments.
  - ACK: RISE pulses bit_valid and ack_valid, latches ack_bit, sets bit_cnt = 0, state -> DATA.
  - START in DATA or ACK (repeated START): start_det pulses, state -> DATA, bit_cnt = 0. frame_err also pulses if bit_cnt != 0 in DATA.
  - STOP in DATA or ACK: stop_det pulses, bus_busy = 0, state -> IDLE. frame_err also pulses if bit_cnt != 0 in DATA.
  - STOP or START while in ACK state is not an error.
- Latency: a pin edge reaches its output pulse SYNC_STAGES + 1 clk cycles after the pin changes, excluding the filter.
- All outputs are registered. Event pulses last exactly one cycle. At most one of start_det and stop_det is high in any cycle.

Optional Feature:
I2C_GLITCH_FILTER_EN
- Defined: each line gets a saturating counter after its synchronizer. The clean value updates only after FILT_LEN consecutive samples that differ from the current clean value. Pulses narrower than FILT_LEN cycles are rejected. Latency increases by FILT_LEN cycles.
- Undefined: the clean lines equal the synchronizer outputs directly, and FILT_LEN is unused.

Test Plan:
1. Send START, byte 0xA6, ACK = 0, STOP -> start_det once; eight bit_valid pulses with values 1,0,1,0,0,1,1,0; byte_valid with byte_data = 0xA6; ack_valid with ack_bit = 0; stop_det once; bus_busy high from start_det until stop_det.
2. Send START, 0x3C with NACK, repeated START, 0xFF with ACK, STOP -> two start_det pulses, no frame_err, bytes 0x3C then 0xFF, ack_bit 1 then 0.
3. Send START, 3 data bits, STOP -> frame_err and stop_det in the same cycle; no byte_valid; bus_busy = 0; FSM back in IDLE.
4. With bus idle, toggle scl 5 times with sda = 1 and no START -> no bit_valid or byte_valid pulses; bus_busy stays 0.
5. Assert reset after 4 bits of a byte, deassert, then send a full frame with 0x81 -> no pulses during reset; next byte_valid shows 0x81, not stale data.
6. Filter defined, FILT_LEN = 3: inject a 2-cycle low glitch on sda while scl is high -> no start_det. A 4-cycle low -> start_det, SYNC_STAGES + 1 + 3 cycles after the falling edge.
